// File: rtl/energy_telemetry_pkg.sv
// Shared constants and frame-state encoding for the energy telemetry UART.
// Optional min/max trailer bytes are enabled by TELEM_MINMAX_EN.
package energy_telemetry_pkg;

  localparam logic [7:0] TELEM_HDR            = 8'hA5;
  localparam int         TELEM_FRAME_OVERHEAD = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEQ  = 3'd2,
    DATA = 3'd3,
    MINV = 3'd4,
    MAXV = 3'd5,
    CSUM = 3'd6
  } frame_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// A load on the final stop-bit cycle chains the next byte with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       near_done,
  output logic       tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic          active;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tx_q;
  logic          bit_end;

  assign bit_end   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign busy      = active;
  assign tx        = tx_q;
  assign done      = active && (bit_idx == 4'd9) && bit_end;
  // One cycle ahead of done, so the frame FSM can release busy on time.
  assign near_done = active && (bit_idx == 4'd9) && (baud_cnt == BW'(CLKS_PER_BIT - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      shreg    <= 8'h00;
      tx_q     <= 1'b1;
    end else if (load) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      shreg    <= data;
      tx_q     <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        bit_idx  <= bit_idx + 4'd1;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          tx_q   <= 1'b1;
        end else if (bit_idx == 4'd8) begin
          tx_q <= 1'b1;
        end else begin
          tx_q  <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/energy_telemetry_uart.sv
// Telemetry framer: sample FIFO feeding A5/seq/data/checksum frames onto a UART pin.
// Define TELEM_MINMAX_EN to append min and max data bytes ahead of the checksum.
module energy_telemetry_uart
  import energy_telemetry_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int FRAME_LEN    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    head;
  logic          push_req, push_ok, full, pop;

  frame_state_e  state;
  logic [7:0]    seq, csum, data_cnt;
  logic          tx_load, tx_busy, tx_done, tx_near_done;
  logic [7:0]    tx_data;
  logic          last_data;
`ifdef TELEM_MINMAX_EN
  logic [7:0]    min_v, max_v;
`endif

  assign head      = mem[rd_ptr];
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign push_req  = sample_valid && ena;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push_req && (!full || pop);
  assign busy      = (state != IDLE);
  assign last_data = (data_cnt == 8'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  always_comb begin
    tx_load = 1'b0;
    tx_data = 8'h00;
    pop     = 1'b0;
    unique case (state)
      HDR: begin
        if (!tx_busy) begin
          tx_load = 1'b1;
          tx_data = TELEM_HDR;
        end else if (tx_done) begin
          tx_load = 1'b1;
          tx_data = seq;
        end
      end
      SEQ: begin
        if (tx_done) begin
          tx_load = 1'b1;
          tx_data = head;
          pop     = 1'b1;
        end
      end
      DATA: begin
        if (tx_done) begin
          tx_load = 1'b1;
          if (!last_data) begin
            tx_data = head;
            pop     = 1'b1;
          end else begin
`ifdef TELEM_MINMAX_EN
            tx_data = min_v;
`else
            tx_data = csum;
`endif
          end
        end
      end
`ifdef TELEM_MINMAX_EN
      MINV: begin
        if (tx_done) begin
          tx_load = 1'b1;
          tx_data = max_v;
        end
      end
      MAXV: begin
        if (tx_done) begin
          tx_load = 1'b1;
          tx_data = csum;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      seq        <= 8'h00;
      csum       <= 8'h00;
      data_cnt   <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: if (count >= (AW+1)'(FRAME_LEN)) state <= HDR;
        HDR: begin
          if (tx_busy && tx_done) begin
            state <= SEQ;
            csum  <= seq;
          end
        end
        SEQ: begin
          if (tx_done) begin
            state    <= DATA;
            data_cnt <= 8'h00;
            csum     <= csum + head;
          end
        end
        DATA: begin
          if (tx_done) begin
            if (last_data) begin
`ifdef TELEM_MINMAX_EN
              state <= MINV;
`else
              state <= CSUM;
`endif
            end else begin
              data_cnt <= data_cnt + 8'd1;
              csum     <= csum + head;
            end
          end
        end
`ifdef TELEM_MINMAX_EN
        MINV: begin
          if (tx_done) begin
            state <= MAXV;
            csum  <= csum + min_v;
          end
        end
        MAXV: begin
          if (tx_done) begin
            state <= CSUM;
            csum  <= csum + max_v;
          end
        end
`endif
        CSUM: begin
          if (tx_near_done) begin
            state      <= IDLE;
            seq        <= seq + 8'd1;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TELEM_MINMAX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_v <= 8'h00;
      max_v <= 8'h00;
    end else if (pop) begin
      // The first pop of a frame comes from SEQ and seeds both extremes.
      if (state == SEQ || head < min_v) min_v <= head;
      if (state == SEQ || head > max_v) max_v <= head;
    end
  end
`endif

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .data      (tx_data),
    .busy      (tx_busy),
    .done      (tx_done),
    .near_done (tx_near_done),
    .tx        (tx)
  );

endmodule

// File: tb/tb_energy_telemetry_uart.sv
// Self-checking bench for energy_telemetry_uart: randomized samples, frame model,
// UART line decoder and byte scoreboard.
module tb_energy_telemetry_uart;

  localparam int CPB        = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_LEN  = 4;
`ifdef TELEM_MINMAX_EN
  localparam int FRAME_BYTES = FRAME_LEN + 5;
`else
  localparam int FRAME_BYTES = FRAME_LEN + 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       tx, busy, frame_done, overflow;

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt = 0;

  // reference model state
  logic [7:0] exp_q[$];
  logic [7:0] pend_q[$];
  int         occ = 0;
  logic [7:0] m_seq = 8'h00;
  logic       m_ovf = 1'b0;

  energy_telemetry_uart #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .FRAME_LEN   (FRAME_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .tx          (tx),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame contents follow directly from the sample list and the sequence number.
  task automatic build_frame();
    logic [7:0] sum, mn, mx, d;
    exp_q.push_back(8'hA5);
    exp_q.push_back(m_seq);
    sum = m_seq;
    mn  = 8'hFF;
    mx  = 8'h00;
    for (int i = 0; i < FRAME_LEN; i++) begin
      d = pend_q.pop_front();
      exp_q.push_back(d);
      sum = sum + d;
      if (d < mn) mn = d;
      if (d > mx) mx = d;
    end
`ifdef TELEM_MINMAX_EN
    exp_q.push_back(mn);
    exp_q.push_back(mx);
    sum = sum + mn + mx;
`endif
    exp_q.push_back(sum);
    m_seq = m_seq + 8'd1;
  endtask

  task automatic model_push(logic [7:0] d);
    if (occ < FIFO_DEPTH) begin
      occ++;
      pend_q.push_back(d);
      if (pend_q.size() == FRAME_LEN) build_frame();
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_q.delete();
    occ   = 0;
    m_seq = 8'h00;
    m_ovf = 1'b0;
  endtask

  // Inputs change on the falling edge; the following rising edge samples them.
  task automatic push_cycle(logic [7:0] d, logic en);
    sample_in    = d;
    sample_valid = 1'b1;
    ena          = en;
    if (en) model_push(d);
    @(negedge clk);
    sample_valid = 1'b0;
    ena          = 1'b1;
  endtask

  task automatic idle(int n);
    sample_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame(string tag);
    int start, n;
    start = fd_cnt;
    n     = 0;
    while (fd_cnt == start && n < 600) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_in_time"}, (n < 600), 1);
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_once"}, fd_cnt - start, 1);
    occ = (occ >= FRAME_LEN) ? occ - FRAME_LEN : 0;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < FRAME_LEN; i++) begin
      if ($urandom_range(3, 0) == 0) push_cycle(8'($urandom_range(255, 0)), 1'b0);
      push_cycle(8'($urandom_range(255, 0)), 1'b1);
      idle($urandom_range(1, 0));
    end
    wait_frame("rand");
  endtask

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  // UART line decoder: samples mid-bit and scores each byte against the model.
  logic [9:0] rx_bits;
  bit         rx_abort;
  always begin
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) begin
      rx_abort = 1'b0;
      rx_bits  = '0;
      for (int i = 0; i < 10; i++) begin
        for (int k = 0; k < ((i == 0) ? CPB / 2 : CPB); k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            rx_abort = 1'b1;
            break;
          end
        end
        if (rx_abort) break;
        rx_bits[i] = tx;
      end
      if (!rx_abort) begin
        check_eq("rx_start", rx_bits[0], 0);
        check_eq("rx_stop", rx_bits[9], 1);
        check_eq("rx_byte_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check_eq("rx_byte", rx_bits[8:1], exp_q.pop_front());
      end
    end
  end

  initial begin : main
    int busy_cnt, low_cnt, fd_start;

    // reset
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    idle(2);

    // 1: basic frame with latency and busy width
    fd_start = fd_cnt;
    push_cycle(8'h10, 1'b1);
    push_cycle(8'h20, 1'b1);
    push_cycle(8'h30, 1'b1);
    push_cycle(8'h40, 1'b1);
    check_eq("lat_busy_n0", busy, 0);
    @(negedge clk);
    check_eq("lat_busy_n1", busy, 1);
    check_eq("lat_tx_n1", tx, 1);
    @(negedge clk);
    check_eq("lat_tx_n2", tx, 0);
    busy_cnt = 2;
    for (int i = 0; i < 1000 && busy === 1'b1; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
    end
    check_eq("basic_busy_cycles", busy_cnt, FRAME_BYTES * 10 * CPB);
    idle(2);
    check_eq("basic_done_once", fd_cnt - fd_start, 1);
    check_eq("basic_overflow", overflow, m_ovf);
    occ = 0;

    // 2: two further frames, seq 01 and 02
    rand_frame();
    rand_frame();

    // 3: overflow on a fifth back-to-back sample
    for (int i = 0; i < 5; i++) push_cycle(8'($urandom_range(255, 0)), 1'b1);
    check_eq("ovf_set", overflow, m_ovf);
    check_eq("ovf_model", m_ovf, 1);
    wait_frame("ovf");
    check_eq("ovf_held", overflow, 1);

    // 4: ena low ignores samples
    for (int i = 0; i < 4; i++) push_cycle(8'($urandom_range(255, 0)), 1'b0);
    low_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) low_cnt++;
    end
    check_eq("ena_quiet", low_cnt, 0);
    rand_frame();

    // sequence wrap with random frames, then an all-FF frame at seq 00
    while (m_seq != 8'h00) rand_frame();
    for (int i = 0; i < 4; i++) push_cycle(8'hFF, 1'b1);
    wait_frame("wrap_ff");
    check_eq("wrap_overflow", overflow, m_ovf);

    // 5: reset in the middle of the DATA phase
    for (int i = 0; i < 4; i++) push_cycle(8'($urandom_range(255, 0)), 1'b1);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_tx", tx, 1);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_overflow", overflow, 0);
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) push_cycle(8'($urandom_range(255, 0)), 1'b1);
    wait_frame("post_rst");
    check_eq("post_rst_busy", busy, 0);

    idle(5);
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
